// File: rtl/dsp_post_adder.sv
// Post-adder/accumulator stage of a DSP48A1-style slice: X/Z operand muxes,
// add/subtract with carry-in, optional OPMODE/carry-in/P pipeline registers.
module dsp_post_adder #(
  parameter int unsigned OPMODEREG  = 1,
  parameter int unsigned CARRYINREG = 1,
  parameter int unsigned PREG       = 1,
  parameter string       CARRYINSEL = "OPMODE5"
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ceopmode,
  input  logic          cecarryin,
  input  logic          cep,
  input  logic [7:0]    opmode,
  input  logic          carryin,
  input  logic [35:0]   m,
  input  logic [47:0]   dab,
  input  logic [47:0]   c,
  input  logic [47:0]   pcin,
  output logic [47:0]   p,
  output logic [47:0]   pcout,
  output logic          carryout,
  output logic          carryoutf
);

  localparam int unsigned W  = 48;
  localparam int unsigned MW = 36;
  localparam bit CIN_FROM_PORT = (CARRYINSEL == "CARRYIN");

  logic [3:0]   sel_c;
  logic         sub_c;
  logic         cin_src_c;
  logic         cin_c;
  logic [W-1:0] p_fb_c;
  logic [W-1:0] x_c;
  logic [W-1:0] z_c;
  logic [W:0]   res_c;

  // Inputs that some parameterisations leave unread (bits 4/6 of opmode are don't-care).
  logic unused_inputs;
  assign unused_inputs = ^{opmode[6], opmode[4], opmode[5], carryin, clk, reset,
                           ceopmode, cecarryin, cep};

  // OPMODE stage: only the bits the datapath consumes are kept.
  generate
    if (OPMODEREG != 0) begin : g_opmode_reg
      logic [3:0] sel_r;
      logic       sub_r;
      always_ff @(posedge clk) begin
        if (reset) begin
          sel_r <= 4'd0;
          sub_r <= 1'b0;
        end else if (ceopmode) begin
          sel_r <= opmode[3:0];
          sub_r <= opmode[7];
        end
      end
      assign sel_c = sel_r;
      assign sub_c = sub_r;
    end else begin : g_opmode_comb
      assign sel_c = opmode[3:0];
      assign sub_c = opmode[7];
    end
  endgenerate

  assign cin_src_c = CIN_FROM_PORT ? carryin : opmode[5];

  // Carry-in stage sits after the source select.
  generate
    if (CARRYINREG != 0) begin : g_cin_reg
      logic cin_r;
      always_ff @(posedge clk) begin
        if (reset) begin
          cin_r <= 1'b0;
        end else if (cecarryin) begin
          cin_r <= cin_src_c;
        end
      end
      assign cin_c = cin_r;
    end else begin : g_cin_comb
      assign cin_c = cin_src_c;
    end
  endgenerate

  // Operand muxes and 49-bit add/subtract; co is the carry (add) or borrow (sub).
  always_comb begin
    x_c = '0;
    z_c = '0;
    case (sel_c[1:0])
      2'd0:    x_c = '0;
      2'd1:    x_c = {(W-MW)'(0), m};
      2'd2:    x_c = p_fb_c;
      default: x_c = dab;
    endcase
    case (sel_c[3:2])
      2'd0:    z_c = '0;
      2'd1:    z_c = pcin;
      2'd2:    z_c = p_fb_c;
      default: z_c = c;
    endcase
    if (sub_c) begin
      res_c = {1'b0, z_c} - ({1'b0, x_c} + (W+1)'(cin_c));
    end else begin
      res_c = {1'b0, z_c} + {1'b0, x_c} + (W+1)'(cin_c);
    end
  end

  // P/CARRYOUT stage; without it the feedback operand is forced to zero to avoid a loop.
  generate
    if (PREG != 0) begin : g_p_reg
      logic [W-1:0] p_r;
      logic         co_r;
      always_ff @(posedge clk) begin
        if (reset) begin
          p_r  <= '0;
          co_r <= 1'b0;
        end else if (cep) begin
          p_r  <= res_c[W-1:0];
          co_r <= res_c[W];
        end
      end
      assign p_fb_c   = p_r;
      assign p        = p_r;
      assign carryout = co_r;
    end else begin : g_p_comb
      assign p_fb_c   = '0;
      assign p        = res_c[W-1:0];
      assign carryout = res_c[W];
    end
  endgenerate

  assign pcout     = p;
  assign carryoutf = carryout;

endmodule
